// File: rtl/game_pkg.sv
// Shared encodings for the game-rate logic: mode select, button indices,
// speed FSM states and the default coordinate width.
package game_pkg;

  typedef enum logic [1:0] {
    MODE_STEP   = 2'b00,
    MODE_ACCEL  = 2'b01,
    MODE_WRAP   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  localparam int BTN_HOME  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_UP    = 4;

  typedef enum logic [1:0] {
    SPD_IDLE   = 2'b00,
    SPD_RAMP   = 2'b01,
    SPD_CRUISE = 2'b10
  } spd_state_e;

  localparam int COORD_W_DEF = 11;

endpackage

// File: rtl/tick_gen.sv
// Free-running game-rate divider: a registered one-cycle pulse every TICK_CYCLES clocks.
// tick_due is high in the cycle before the pulse, so state can update on the pulse edge.
module tick_gen #(
  parameter int TICK_CYCLES = 3333334
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_due
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_due = (cnt == CNT_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= tick_due ? '0 : cnt + 1'b1;
      tick <= tick_due;
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// Button-driven motion controller for one on-screen block: synchronised inputs,
// accelerate FSM and a saturating / wrapping position datapath stepped once per game tick.
module sprite_motion
  import game_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int TICK_CYCLES = 3333334,
  parameter int STEP        = 4,
  parameter int MAX_STEP    = 16,
  parameter int ACCEL_TICKS = 8,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 1380,
  parameter int Y_MIN       = 10,
  parameter int Y_MAX       = 840,
  parameter int HOME_X      = 10,
  parameter int HOME_Y      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         btn,
  input  logic [1:0]         mode,
  output logic [COORD_W-1:0] blkpos_x,
  output logic [COORD_W-1:0] blkpos_y,
  output logic               tick,
  output logic               moving,
  output logic [3:0]         at_edge
);

  localparam logic [COORD_W-1:0] X_LO   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_HI   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] X_HOME = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] Y_HOME = COORD_W'(HOME_Y);
  localparam logic [COORD_W-1:0] SPD_LO = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] SPD_HI = COORD_W'(MAX_STEP);
  localparam int                 HOLD_W = (ACCEL_TICKS > 2) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);

  logic [4:0]   btn_s1, btn_s2;
  logic [1:0]   mode_s1, mode_s2;
  mode_e        mode_q;
  logic         tick_due;
  logic         home, x_inc, x_dec, y_inc, y_dec, held;

  spd_state_e         state, state_nxt;
  logic [COORD_W-1:0] speed, speed_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .tick_due (tick_due)
  );

  // NOTE: every register is written with <= so all flops sample pre-edge values
  // together; blocking assignments here would collapse the two sync stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
    end else begin
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
    end
  end

  assign mode_q = mode_e'(mode_s2);
  assign home   = btn_s2[BTN_HOME];
  assign x_inc  = btn_s2[BTN_RIGHT] & ~btn_s2[BTN_LEFT];
  assign x_dec  = btn_s2[BTN_LEFT]  & ~btn_s2[BTN_RIGHT];
  assign y_inc  = btn_s2[BTN_UP]    & ~btn_s2[BTN_DOWN];
  assign y_dec  = btn_s2[BTN_DOWN]  & ~btn_s2[BTN_UP];
  assign held   = x_inc | x_dec | y_inc | y_dec;

  // Speed FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SPD_IDLE;
      speed    <= SPD_LO;
      hold_cnt <= '0;
    end else if (tick_due) begin
      state    <= state_nxt;
      speed    <= speed_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Speed FSM: next state. speed_nxt is also the step applied on this tick,
  // so a speed increment takes effect on the tick that earns it.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    hold_nxt  = hold_cnt;
    if (home || mode_q != MODE_ACCEL || !held) begin
      state_nxt = SPD_IDLE;
      speed_nxt = SPD_LO;
      hold_nxt  = '0;
    end else begin
      unique case (state)
        SPD_IDLE: begin
          state_nxt = (SPD_LO >= SPD_HI) ? SPD_CRUISE : SPD_RAMP;
          speed_nxt = SPD_LO;
          hold_nxt  = '0;
        end
        SPD_RAMP: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_nxt = '0;
            if (speed + SPD_LO >= SPD_HI) begin
              state_nxt = SPD_CRUISE;
              speed_nxt = SPD_HI;
            end else begin
              speed_nxt = speed + SPD_LO;
            end
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        SPD_CRUISE: speed_nxt = SPD_HI;
        default: begin
          state_nxt = SPD_IDLE;
          speed_nxt = SPD_LO;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // One axis step. Compares run one bit wider so lo+spd and pos+spd cannot overflow;
  // the same crossing test drives saturation and wrap, only the landing bound differs.
  function automatic logic [COORD_W-1:0] axis_move(
    input logic [COORD_W-1:0] pos,
    input logic               inc,
    input logic               dec,
    input logic [COORD_W-1:0] spd,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi,
    input logic               wrap
  );
    logic [COORD_W:0] pos_w, spd_w, lo_w, hi_w;
    pos_w = {1'b0, pos};
    spd_w = {1'b0, spd};
    lo_w  = {1'b0, lo};
    hi_w  = {1'b0, hi};
    if (dec) begin
      axis_move = (pos_w < lo_w + spd_w) ? (wrap ? hi : lo) : pos - spd;
    end else if (inc) begin
      axis_move = (pos_w + spd_w > hi_w) ? (wrap ? lo : hi) : pos + spd;
    end else begin
      axis_move = pos;
    end
  endfunction

  // Speed FSM: outputs, i.e. the position the current speed produces on this tick
  always_comb begin
    x_nxt = blkpos_x;
    y_nxt = blkpos_y;
    if (home) begin
      x_nxt = X_HOME;
      y_nxt = Y_HOME;
    end else if (mode_q != MODE_FREEZE) begin
      x_nxt = axis_move(blkpos_x, x_inc, x_dec, speed_nxt, X_LO, X_HI, mode_q == MODE_WRAP);
      y_nxt = axis_move(blkpos_y, y_inc, y_dec, speed_nxt, Y_LO, Y_HI, mode_q == MODE_WRAP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blkpos_x <= X_HOME;
      blkpos_y <= Y_HOME;
      moving   <= 1'b0;
    end else if (tick_due) begin
      blkpos_x <= x_nxt;
      blkpos_y <= y_nxt;
      moving   <= (x_nxt != blkpos_x) || (y_nxt != blkpos_y);
    end
  end

  assign at_edge = {blkpos_y == Y_HI, blkpos_y == Y_LO, blkpos_x == X_HI, blkpos_x == X_LO};

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench for sprite_motion: a tick-level behavioural model compared every
// cycle, directed scenarios pinned with literal values, then randomized buttons and modes.
module tb_sprite_motion;
  import game_pkg::*;

  localparam int CW = 11;
  localparam int TC = 4;
  localparam int ST = 4;
  localparam int MS = 12;
  localparam int AT = 2;
  localparam int LO = 10;
  localparam int HI = 50;
  localparam int HX = 10;
  localparam int HY = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    btn = '0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] blkpos_x, blkpos_y;
  logic          tick, moving;
  logic [3:0]    at_edge;

  sprite_motion #(
    .COORD_W(CW), .TICK_CYCLES(TC), .STEP(ST), .MAX_STEP(MS), .ACCEL_TICKS(AT),
    .X_MIN(LO), .X_MAX(HI), .Y_MIN(LO), .Y_MAX(HI), .HOME_X(HX), .HOME_Y(HY)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode),
    .blkpos_x(blkpos_x), .blkpos_y(blkpos_y),
    .tick(tick), .moving(moving), .at_edge(at_edge)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model state: position, length of the current accelerate-mode hold run, moving flag
  int mx = HX, my = HY, run = 0;
  int mmov = 0;
  int cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic int move_axis(input int pos, input int dir, input int spd, input bit wrap);
    int t;
    t = pos + dir * spd;
    if (t < LO) return wrap ? HI : LO;
    if (t > HI) return wrap ? LO : HI;
    return t;
  endfunction

  task automatic model_tick(input logic [4:0] b, input logic [1:0] m);
    int dx, dy, spd, nx, ny;
    dx = int'(b[BTN_RIGHT]) - int'(b[BTN_LEFT]);
    dy = int'(b[BTN_UP]) - int'(b[BTN_DOWN]);
    nx = mx;
    ny = my;
    if (b[BTN_HOME]) begin
      nx  = HX;
      ny  = HY;
      run = 0;
    end else begin
      // speed climbs one STEP every AT held ticks, capped at MS
      if (m == MODE_ACCEL && (dx != 0 || dy != 0)) begin
        run++;
        spd = ST * (1 + (run - 1) / AT);
        if (spd > MS) spd = MS;
      end else begin
        run = 0;
        spd = ST;
      end
      if (m != MODE_FREEZE) begin
        nx = move_axis(mx, dx, spd, m == MODE_WRAP);
        ny = move_axis(my, dy, spd, m == MODE_WRAP);
      end
    end
    mmov = (nx != mx || ny != my) ? 1 : 0;
    mx = nx;
    my = ny;
  endtask

  // Per-cycle compare; inputs are only changed just after a tick, so btn/mode seen
  // here on a tick cycle are the levels the DUT sampled.
  initial begin
    int exp_tick;
    forever begin
      @(negedge clk);
      exp_tick = 0;
      if (!rst) begin
        mx = HX; my = HY; run = 0; mmov = 0;
      end else if (cyc != 0 && cyc % TC == 0) begin
        model_tick(btn, mode);
        exp_tick = 1;
      end
      check("tick", int'(tick), exp_tick);
      check("blkpos_x", int'(blkpos_x), mx);
      check("blkpos_y", int'(blkpos_y), my);
      check("moving", int'(moving), mmov);
      check("at_edge", int'(at_edge), int'({my == HI, my == LO, mx == HI, mx == LO}));
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!tick && g < 3 * TC);
      if (!tick) check("tick_timeout", 0, 1);
      #1;
    end
  endtask

  initial begin
    int ey[6] = '{14, 18, 26, 34, 46, 50};
    logic [4:0] b, g;
    repeat (3) @(negedge clk);
    check("rst_at_edge", int'(at_edge), 5);
    check("rst_x", int'(blkpos_x), 10);
    #1 rst = 1'b1;
    wait_ticks(2);
    check("idle_pos", mx * 100 + my, 1010);

    // Step mode, hold right: 10 moves reach 50, the 11th holds
    mode = MODE_STEP; btn = 5'b01000;
    wait_ticks(10);
    check("step_x_model", mx, 50);
    check("step_x_dut", int'(blkpos_x), 50);
    check("step_moving", int'(moving), 1);
    wait_ticks(1);
    check("step_sat_moving", mmov, 0);
    check("step_sat_edge", int'(at_edge[1]), 1);

    btn = 5'b00001;
    wait_ticks(1);
    check("home_x", mx, 10);

    // Accelerate mode, hold up
    mode = MODE_ACCEL; btn = 5'b10000;
    for (int i = 0; i < 6; i++) begin
      wait_ticks(1);
      check("accel_y_model", my, ey[i]);
      check("accel_y_dut", int'(blkpos_y), ey[i]);
    end
    btn = 5'b00000; wait_ticks(1);
    btn = 5'b00010; wait_ticks(1);
    check("accel_restart_y", my, 46);

    // Wrap mode
    btn = 5'b00001; wait_ticks(1);
    mode = MODE_WRAP; btn = 5'b01000; wait_ticks(1);
    check("wrap_x14", mx, 14);
    btn = 5'b00100; wait_ticks(1);
    check("wrap_x10", mx, 10);
    wait_ticks(1);
    check("wrap_x50", int'(blkpos_x), 50);
    btn = 5'b01100; wait_ticks(1);
    check("cancel_x", mx, 50);
    check("cancel_moving", int'(moving), 0);

    // Freeze mode
    mode = MODE_FREEZE; btn = 5'b11110; wait_ticks(3);
    check("freeze_pos", mx * 100 + my, 5010);
    btn = 5'b11111; wait_ticks(1);
    check("freeze_home", int'(blkpos_x) * 100 + int'(blkpos_y), 1010);
    check("freeze_home_moving", mmov, 1);

    // Reset in the middle of an acceleration run at speed 8
    mode = MODE_ACCEL; btn = 5'b10000; wait_ticks(3);
    check("pre_rst_y", my, 26);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_y", int'(blkpos_y), 10);
    check("rst_mid_tick", int'(tick), 0);
    check("rst_mid_moving", int'(moving), 0);
    check("rst_mid_edge", int'(at_edge), 5);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    wait_ticks(1);
    check("post_rst_y_model", my, 14);
    check("post_rst_y_dut", int'(blkpos_y), 14);

    // Randomized buttons and modes, with short pulses between ticks that must be ignored
    repeat (150) begin
      b = 5'($urandom);
      if ($urandom_range(0, 9) != 0) b[BTN_HOME] = 1'b0;
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        g = 5'($urandom) & 5'b11110;
        btn = b ^ g;
        @(negedge clk);
        #1;
      end
      btn = b;
      wait_ticks($urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
